// File: rtl/spi_frame_pkg.sv
// Shared constants and state type for the SPI frame decoder.
// Optional build macro: FRAME_CHECKSUM_EN adds the CHECK state.
package spi_frame_pkg;

    localparam logic [7:0] SYNC0     = 8'h55;
    localparam logic [7:0] SYNC1     = 8'h5B;
    localparam logic [7:0] STOP_BYTE = 8'hAA;

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_STOP    = 3'd3,
        ST_CHECK   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_STOP    = 3'd3
    } state_e;
`endif

endpackage

// File: rtl/spi_frame_decoder_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES idle cycles have accumulated.
module spi_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clear,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: held at zero when disabled or cleared, saturates at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || !i_en) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = (cnt_q == LIMIT);

endmodule

// File: rtl/spi_frame_decoder.sv
// SPI frame parser: 0x55 0x5B header, LEDS*3 payload bytes written to the
// back buffer, 0xAA stop byte. Aborts on CS release or inter-byte timeout.
// Optional build macro: FRAME_CHECKSUM_EN (XOR checksum byte before stop).
module spi_frame_decoder
    import spi_frame_pkg::*;
#(
    parameter int unsigned LEDS           = 120,
    parameter int unsigned ADDR_WIDTH     = $clog2(LEDS * 3),
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_cs,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [7:0]            o_wr_data,
    output logic                  o_frame_done,
    output logic                  o_frame_error,
    output logic [7:0]            o_err_count,
    output logic                  o_busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LEDS * 3 - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic timeout_expire;
    logic abort;

    spi_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (state_q != ST_IDLE),
        .i_clear (i_rx_valid),
        .o_expire(timeout_expire)
    );

    // Frame parser next-state and registered-output logic.
    // Abort (CS high or timeout) is evaluated before the byte so it wins.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        abort     = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        if (state_q != ST_IDLE && (i_cs || timeout_expire)) begin
            abort = 1'b1;
        end else if (i_rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (!i_cs && i_rx_data == SYNC0) begin
                        state_d = ST_HDR;
                        index_d = '0;
`ifdef FRAME_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                ST_HDR: begin
                    if (i_rx_data == SYNC1) begin
                        state_d = ST_PAYLOAD;
                    end else if (i_rx_data != SYNC0) begin
                        abort = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = index_q;
                    wr_data_d = i_rx_data;
`ifdef FRAME_CHECKSUM_EN
                    csum_d    = csum_q ^ i_rx_data;
`endif
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
`ifdef FRAME_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                ST_CHECK: begin
                    if (i_rx_data == csum_q) begin
                        state_d = ST_STOP;
                    end else begin
                        abort = 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (i_rx_data == STOP_BYTE) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (abort) begin
            state_d = ST_IDLE;
            index_d = '0;
        end

        err_d     = abort;
        err_cnt_d = err_cnt_q;
        if (abort && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // Running XOR of the payload bytes of the current frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign o_wr_en       = wr_en_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_frame_done  = done_q;
    assign o_frame_error = err_q;
    assign o_err_count   = err_cnt_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Self-checking bench for spi_frame_decoder (default and FRAME_CHECKSUM_EN builds).
module tb_spi_frame_decoder;

    localparam int unsigned LEDS   = 120;
    localparam int unsigned NBYTES = LEDS * 3;
    localparam int unsigned AW     = $clog2(NBYTES);
    localparam int unsigned TO     = 50000;

    typedef logic [7:0] bq_t [$];

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          cs;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_done;
    logic          frame_error;
    logic [7:0]    err_count;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Monitor-owned observations
    logic [AW-1:0] wr_addr_log [$];
    logic [7:0]    wr_data_log [$];
    int done_total = 0;
    int err_total  = 0;
    int consec_wr  = 0;
    int both_hi    = 0;
    logic prev_wr  = 1'b0;

    always #5 clk = ~clk;

    spi_frame_decoder #(
        .LEDS          (LEDS),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_cs         (cs),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_frame_done (frame_done),
        .o_frame_error(frame_error),
        .o_err_count  (err_count),
        .o_busy       (busy)
    );

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_addr_log.push_back(wr_addr);
            wr_data_log.push_back(wr_data);
            if (prev_wr) consec_wr++;
        end
        prev_wr = (wr_en === 1'b1);
        if (frame_done === 1'b1) done_total++;
        if (frame_error === 1'b1) err_total++;
        if (frame_done === 1'b1 && frame_error === 1'b1) both_hi++;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_payload(input bq_t p, input int n);
        for (int i = 0; i < n; i++) send_byte(p[i]);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [7:0] xor_of(input bq_t p);
        logic [7:0] x = '0;
        foreach (p[i]) x ^= p[i];
        return x;
    endfunction

    function automatic bq_t rand_payload();
        bq_t p;
        for (int i = 0; i < int'(NBYTES); i++) p.push_back(8'($urandom_range(0, 255)));
        return p;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Full frame: header (optionally doubled sync), payload, [checksum], stop byte.
    task automatic send_frame(input bq_t p, input logic [7:0] stop_b, input bit dbl);
        send_byte(8'h55);
        if (dbl) send_byte(8'h55);
        send_byte(8'h5B);
        send_payload(p, p.size());
`ifdef FRAME_CHECKSUM_EN
        send_byte(xor_of(p));
`endif
        send_byte(stop_b);
    endtask

    task automatic check_writes(input string tag, input int base, input bq_t p, input int n);
        chk({tag, "_nwrites"}, wr_addr_log.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < wr_addr_log.size()) begin
                chk({tag, "_addr"}, 32'(wr_addr_log[base + i]), i);
                chk({tag, "_data"}, 32'(wr_data_log[base + i]), 32'(p[i]));
            end
        end
    endtask

    initial begin
        bq_t        pay;
        logic [7:0] exp_err;
        int         wb, db, eb, k;

        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; cs = 1'b0;
        exp_err = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_error", frame_error, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Counting payload k%256
        pay = {};
        for (int i = 0; i < int'(NBYTES); i++) pay.push_back(8'(i % 256));
        wb = wr_addr_log.size(); db = done_total; eb = err_total;
        send_frame(pay, 8'hAA, 1'b0);
        chk("A_done_pulse", frame_done, 1);
        @(negedge clk);
        chk("A_done_one_cycle", frame_done, 0);
        settle();
        check_writes("A", wb, pay, NBYTES);
        chk("A_done_count", done_total - db, 1);
        chk("A_err_pulses", err_total - eb, 0);
        chk("A_err_count", err_count, 0);
        chk("A_busy", busy, 0);

        // Repeated sync byte
        pay = rand_payload();
        wb = wr_addr_log.size(); db = done_total;
        send_frame(pay, 8'hAA, 1'b1);
        chk("B_done_pulse", frame_done, 1);
        settle();
        check_writes("B", wb, pay, NBYTES);
        chk("B_done_count", done_total - db, 1);

        // Bad stop byte
        pay = rand_payload();
        db = done_total; eb = err_total;
        send_frame(pay, 8'h00, 1'b0);
        exp_err = sat_inc(exp_err);
        chk("C_error_pulse", frame_error, 1);
        chk("C_no_done", frame_done, 0);
        settle();
        chk("C_err_count", err_count, 32'(exp_err));
        chk("C_done_count", done_total - db, 0);
        chk("C_err_pulses", err_total - eb, 1);

        // CS released mid-payload, then a normal frame
        pay = rand_payload();
        wb = wr_addr_log.size(); db = done_total; eb = err_total;
        send_byte(8'h55);
        send_byte(8'h5B);
        send_payload(pay, 100);
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        exp_err = sat_inc(exp_err);
        chk("D_error_pulse", frame_error, 1);
        chk("D_busy", busy, 0);
        repeat (2) @(negedge clk);
        cs = 1'b0;
        settle();
        check_writes("D", wb, pay, 100);
        chk("D_err_count", err_count, 32'(exp_err));
        chk("D_done_count", done_total - db, 0);
        pay = rand_payload();
        wb = wr_addr_log.size(); db = done_total;
        send_frame(pay, 8'hAA, 1'b0);
        chk("D2_done_pulse", frame_done, 1);
        settle();
        check_writes("D2", wb, pay, NBYTES);
        chk("D2_done_count", done_total - db, 1);

        // IDLE ignores bytes while CS high and non-sync bytes
        wb = wr_addr_log.size(); eb = err_total;
        cs = 1'b1;
        send_byte(8'h55);
        send_byte(8'h5B);
        cs = 1'b0;
        send_byte(8'h5B);
        send_byte(8'h12);
        settle();
        chk("E_busy", busy, 0);
        chk("E_err_pulses", err_total - eb, 0);
        chk("E_writes", wr_addr_log.size() - wb, 0);
        chk("E_err_count", err_count, 32'(exp_err));

        // Bad second header byte
        send_byte(8'h55);
        chk("F_busy_hdr", busy, 1);
        send_byte(8'h12);
        exp_err = sat_inc(exp_err);
        chk("F_error_pulse", frame_error, 1);
        settle();
        chk("F_err_count", err_count, 32'(exp_err));

        // Stop byte together with CS release: abort wins
        pay = rand_payload();
        db = done_total;
        send_byte(8'h55);
        send_byte(8'h5B);
        send_payload(pay, NBYTES);
`ifdef FRAME_CHECKSUM_EN
        send_byte(xor_of(pay));
`endif
        @(negedge clk);
        rx_data = 8'hAA; rx_valid = 1'b1; cs = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        exp_err = sat_inc(exp_err);
        chk("G_error_pulse", frame_error, 1);
        chk("G_no_done", frame_done, 0);
        cs = 1'b0;
        settle();
        chk("G_done_count", done_total - db, 0);
        chk("G_err_count", err_count, 32'(exp_err));

`ifdef FRAME_CHECKSUM_EN
        // Checksum feature: all-0x01 payload XORs to 0x00
        pay = {};
        for (int i = 0; i < int'(NBYTES); i++) pay.push_back(8'h01);
        db = done_total;
        send_frame(pay, 8'hAA, 1'b0);
        chk("H_done_pulse", frame_done, 1);
        settle();
        chk("H_done_count", done_total - db, 1);
        db = done_total; eb = err_total;
        send_byte(8'h55);
        send_byte(8'h5B);
        send_payload(pay, NBYTES);
        send_byte(8'h01);
        exp_err = sat_inc(exp_err);
        chk("H_bad_csum_error", frame_error, 1);
        send_byte(8'hAA);
        settle();
        chk("H_bad_done_count", done_total - db, 0);
        chk("H_bad_err_count", err_count, 32'(exp_err));
`endif

        // Inter-byte timeout after header + 5 bytes
        pay = rand_payload();
        wb = wr_addr_log.size(); db = done_total;
        send_byte(8'h55);
        send_byte(8'h5B);
        send_payload(pay, 5);
        chk("T_busy_before", busy, 1);
        k = 0;
        while (frame_error !== 1'b1 && k < int'(TO) + 50) begin
            @(negedge clk);
            k++;
        end
        exp_err = sat_inc(exp_err);
        chk("T_error_seen", frame_error, 1);
        chk("T_latency_in_window", 32'((k >= int'(TO)) && (k <= int'(TO) + 2)), 1);
        chk("T_busy_after", busy, 0);
        settle();
        check_writes("T", wb, pay, 5);
        chk("T_err_count", err_count, 32'(exp_err));
        chk("T_done_count", done_total - db, 0);

        // Saturation of the error counter
        eb = err_total;
        for (int i = 0; i < 260; i++) begin
            send_byte(8'h55);
            send_byte(8'h00);
            exp_err = sat_inc(exp_err);
        end
        settle();
        chk("S_err_pulses", err_total - eb, 260);
        chk("S_err_count", err_count, 32'(exp_err));
        chk("S_err_count_sat", err_count, 8'hFF);

        chk("never_consecutive_wr", consec_wr, 0);
        chk("done_error_exclusive", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_frame_decoder.md
Name: spi_frame_decoder

Overview:
Sits between spi_slave and double_buffer in the SPI-to-NeoPixel path. Takes the byte stream (byte + 1-cycle valid strobe) and parses frames: header 0x55 0x5B, LEDS*3 payload bytes, stop byte 0xAA. Issues one registered write per payload byte into the back buffer and pulses frame-done only for a well-formed frame. Aborts on CS release or inter-byte timeout, and counts every error.

Parameters:
LEDS, 120, number of pixels; payload length is LEDS*3 bytes
ADDR_WIDTH, $clog2(LEDS*3), width of the write address
TIMEOUT_CYCLES, 50000, clock cycles with no valid byte before an in-frame abort (1 ms at 50 MHz)

Ports:
i_clk  in  1  system clock (50 MHz)
i_rst_n  in  1  asynchronous active-low reset
i_rx_data  in  8  received byte from spi_slave
i_rx_valid  in  1  1-cycle strobe; i_rx_data is valid in that cycle
i_cs  in  1  SPI chip select, already synchronised, active-low
o_wr_en  out  1  back-buffer write strobe
o_wr_addr  out  ADDR_WIDTH  back-buffer write address
o_wr_data  out  8  back-buffer write data
o_frame_done  out  1  1-cycle pulse: complete, valid frame received
o_frame_error  out  1  1-cycle pulse: frame aborted
o_err_count  out  8  saturating count of aborted frames
o_busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, i_rst_n low): state IDLE; index 0; all outputs 0.
- States: IDLE, HDR, PAYLOAD, STOP, plus CHECK when the optional feature is compiled in.
- IDLE: a valid byte of 0x55 moves to HDR and clears the index. Any other byte is ignored without an error.
- HDR:
  - valid 0x5B -> PAYLOAD.
  - valid 0x55 -> stay in HDR (repeated sync byte).
  - any other valid byte -> IDLE with an error.
- PAYLOAD, per valid byte, in the cycle after the strobe:
  - o_wr_en=1, o_wr_addr=index, o_wr_data=byte (1-cycle registered latency).
  - o_wr_en is never high for two consecutive cycles.
  - Index increments. When the byte just written is index LEDS*3-1, go to STOP (or CHECK); the index never reaches LEDS*3.
- STOP: valid 0xAA -> o_frame_done=1 for one cycle, then IDLE. Any other valid byte -> error, then IDLE.
- Abort conditions, checked in any non-IDLE state:
  - i_cs high -> abort.
  - Idle counter reaches TIMEOUT_CYCLES -> abort.
  - The idle counter resets on every valid byte and on entry to HDR.
  - Abort means: o_frame_error pulse, o_err_count increments, state IDLE, no o_frame_done.
- Simultaneous events:
  - i_cs high and a valid byte in the same cycle: abort wins and the byte is dropped.
  - A valid 0xAA arriving together with CS release in STOP still counts as an abort.
- Error pulse vs done pulse: o_frame_error and o_frame_done are mutually exclusive and never high together.
- o_err_count saturates at 255 and is cleared only by reset.
- Partially written frames are left in the back buffer. The missing o_frame_done prevents a swap.
- Bytes received in IDLE while i_cs is high are ignored.

Optional Feature:
FRAME_CHECKSUM_EN.
- Defined: a CHECK state sits between PAYLOAD and STOP. The decoder keeps a running XOR of all payload bytes. The next valid byte must equal that XOR, then go to STOP; a mismatch is an abort with error.
- Undefined: no CHECK state and no XOR register; PAYLOAD goes straight to STOP.

Decomposition:
- Package spi_frame_pkg holds:
  - the state enum typedef;
  - localparams SYNC0=8'h55, SYNC1=8'h5B, STOP_BYTE=8'hAA.
- Sub-module spi_timeout_counter (counter, clear input, expire output) is natural and reusable. Everything else stays in one module.

Test Plan:
- Reset, then 0x55 0x5B, bytes 0..359 (mod 256), 0xAA -> 360 o_wr_en pulses; addr k carries data k%256; exactly one o_frame_done, 1 cycle after 0xAA; o_err_count=0.
- 0x55 0x55 0x5B + full payload + 0xAA -> frame accepted; the first write goes to addr 0.
- Full payload then stop byte 0x00 -> o_frame_error pulse, o_err_count=1, no o_frame_done.
- i_cs raised after 100 payload bytes -> abort, 100 writes seen, error counted; a following full frame is accepted normally.
- Header + 5 bytes then silence for 50000 cycles -> o_frame_error at timeout, state IDLE, o_busy=0.
- With FRAME_CHECKSUM_EN: all-0x01 payload (XOR=0x00), checksum 0x00, stop 0xAA -> done. Checksum 0x01 instead -> error, no done.
